mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 208 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires REG ops to the GPR file and runs one dmem transaction for LOAD/STORE.
// Latency: REG retires the cycle after acceptance; LOAD retires the cycle after dmem_ack is sampled.
// Backpressure: mem_blocked is high while a dmem request is outstanding; optional watchdog via MEM_WB_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         exe_mem,
    input  logic [9:0]   exe_opcode,
    input  logic [127:0] exe_result,
    input  logic [63:0]  exe_rflags,
    input  logic [63:0]  exe_addr,
    input  logic [3:0]   exe_dst,
    output logic         mem_blocked,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [63:0]  dmem_addr,
    output logic [63:0]  dmem_wdata,
    input  logic         dmem_ack,
    input  logic [63:0]  dmem_rdata,
    output logic         wb_valid,
    output logic [3:0]   wb_reg,
    output logic [63:0]  wb_data,
    output logic         wb_hi_valid,
    output logic [63:0]  wb_hi_data,
    output logic [63:0]  wb_rflags,
    output logic         mem_err
);

    typedef enum logic {IDLE, REQ} state_e;

    state_e        state_q, state_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [63:0]   dmem_addr_q, dmem_addr_d;
    logic [63:0]   dmem_wdata_q, dmem_wdata_d;
    logic          is_load_q, is_load_d;
    logic [3:0]    dst_q, dst_d;
    logic          wb_valid_q, wb_valid_d;
    logic [3:0]    wb_reg_q, wb_reg_d;
    logic [63:0]   wb_data_q, wb_data_d;
    logic          wb_hi_valid_q, wb_hi_valid_d;
    logic [63:0]   wb_hi_data_q, wb_hi_data_d;
    logic [63:0]   wb_rflags_q, wb_rflags_d;
    logic          timeout_hit;

    logic op_load, op_store, op_nowb, op_imul;

    // Opcode class decode of the op currently presented by execute
    always_comb begin
        op_load  = (exe_opcode == 10'h040) ||
                   (exe_opcode >= 10'h058 && exe_opcode <= 10'h05F);
        op_store = (exe_opcode == 10'h048) ||
                   (exe_opcode >= 10'h050 && exe_opcode <= 10'h057);
        op_nowb  = (exe_opcode >= 10'h038 && exe_opcode <= 10'h03F) ||
                   (exe_opcode == 10'h084) || (exe_opcode == 10'h085) ||
                   (exe_opcode == 10'h306) || (exe_opcode == 10'h0C3) ||
                   (exe_opcode == 10'h0E9) || (exe_opcode == 10'h0EB) ||
                   (exe_opcode == 10'h105) ||
                   (exe_opcode >= 10'h180 && exe_opcode <= 10'h18F);
        op_imul  = (exe_opcode == 10'h0F7);
    end

    // Next-state and next-output logic; writeback strobes default low so they pulse
    always_comb begin
        state_d       = state_q;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        is_load_d     = is_load_q;
        dst_d         = dst_q;
        wb_valid_d    = 1'b0;
        wb_reg_d      = wb_reg_q;
        wb_data_d     = wb_data_q;
        wb_hi_valid_d = 1'b0;
        wb_hi_data_d  = wb_hi_data_q;
        wb_rflags_d   = wb_rflags_q;
        case (state_q)
            IDLE: begin
                if (exe_mem) begin
                    wb_rflags_d = exe_rflags;
                    if (op_load || op_store) begin
                        state_d      = REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = op_store;
                        dmem_addr_d  = exe_addr;
                        dmem_wdata_d = exe_result[63:0];
                        is_load_d    = op_load;
                        dst_d        = exe_dst;
                    end else if (!op_nowb) begin
                        wb_valid_d = 1'b1;
                        wb_reg_d   = exe_dst;
                        wb_data_d  = exe_result[63:0];
                        if (op_imul) begin
                            wb_hi_valid_d = 1'b1;
                            wb_hi_data_d  = exe_result[127:64];
                        end
                    end
                end
            end
            REQ: begin
                // An ack on the watchdog limit edge still completes normally
                if (dmem_ack) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_reg_d   = dst_q;
                        wb_data_d  = dmem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; async reset drops dmem_req immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            is_load_q     <= 1'b0;
            dst_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_reg_q      <= '0;
            wb_data_q     <= '0;
            wb_hi_valid_q <= 1'b0;
            wb_hi_data_q  <= '0;
            wb_rflags_q   <= '0;
        end else begin
            state_q       <= state_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            is_load_q     <= is_load_d;
            dst_q         <= dst_d;
            wb_valid_q    <= wb_valid_d;
            wb_reg_q      <= wb_reg_d;
            wb_data_q     <= wb_data_d;
            wb_hi_valid_q <= wb_hi_valid_d;
            wb_hi_data_q  <= wb_hi_data_d;
            wb_rflags_q   <= wb_rflags_d;
        end
    end

`ifdef MEM_WB_TIMEOUT_EN
    localparam int CW = 16;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;

    // Abort on the edge that would bring the wait count up to the limit
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter clears on REQ entry; error is sticky until reset
    always_comb begin
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!dmem_ack) begin
            cnt_d = cnt_q + 1'b1;
            if (timeout_hit) begin
                mem_err_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign mem_err            = 1'b0;
`endif

    assign mem_blocked = (state_q == REQ);
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_reg      = wb_reg_q;
    assign wb_data     = wb_data_q;
    assign wb_hi_valid = wb_hi_valid_q;
    assign wb_hi_data  = wb_hi_data_q;
    assign wb_rflags   = wb_rflags_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: REG stream, LOAD, PUSH with queued op, NOWB, class edges, reset mid-REQ.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Watchdog scenario runs only when MEM_WB_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

    logic         clk;
    logic         reset_n;
    logic         exe_mem;
    logic [9:0]   exe_opcode;
    logic [127:0] exe_result;
    logic [63:0]  exe_rflags;
    logic [63:0]  exe_addr;
    logic [3:0]   exe_dst;
    logic         mem_blocked;
    logic         dmem_req;
    logic         dmem_we;
    logic [63:0]  dmem_addr;
    logic [63:0]  dmem_wdata;
    logic         dmem_ack;
    logic [63:0]  dmem_rdata;
    logic         wb_valid;
    logic [3:0]   wb_reg;
    logic [63:0]  wb_data;
    logic         wb_hi_valid;
    logic [63:0]  wb_hi_data;
    logic [63:0]  wb_rflags;
    logic         mem_err;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .exe_mem(exe_mem), .exe_opcode(exe_opcode), .exe_result(exe_result),
        .exe_rflags(exe_rflags), .exe_addr(exe_addr), .exe_dst(exe_dst),
        .mem_blocked(mem_blocked),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_hi_valid(wb_hi_valid), .wb_hi_data(wb_hi_data),
        .wb_rflags(wb_rflags), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] op, input logic [127:0] res,
                         input logic [63:0] fl, input logic [63:0] ad, input logic [3:0] dst);
        exe_mem    = 1'b1;
        exe_opcode = op;
        exe_result = res;
        exe_rflags = fl;
        exe_addr   = ad;
        exe_dst    = dst;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; exe_mem = 1'b0; exe_opcode = '0; exe_result = '0;
        exe_rflags = '0; exe_addr = '0; exe_dst = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        checks++;
        if ({mem_blocked, dmem_req, dmem_we, wb_valid, wb_hi_valid, mem_err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000",
                {mem_blocked, dmem_req, dmem_we, wb_valid, wb_hi_valid, mem_err});
        end
        checks++;
        if ((dmem_addr | dmem_wdata | wb_data | wb_hi_data | wb_rflags) !== 64'h0 || wb_reg !== 4'h0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h data=%h hi=%h fl=%h reg=%h exp all 0",
                dmem_addr, dmem_wdata, wb_data, wb_hi_data, wb_rflags, wb_reg);
        end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reg_stream();
        drive(10'h001, 128'h5, 64'h11, 64'h0, 4'd3);
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 4'd3 || wb_data !== 64'h5 || wb_hi_valid !== 1'b0 || mem_blocked !== 1'b0) begin
            errors++; $display("FAIL reg_first got v=%b r=%h d=%h hv=%b blk=%b exp v=1 r=3 d=5 hv=0 blk=0",
                wb_valid, wb_reg, wb_data, wb_hi_valid, mem_blocked);
        end
        checks++;
        if (wb_rflags !== 64'h11) begin
            errors++; $display("FAIL reg_flags got %h exp 11", wb_rflags);
        end
        drive(10'h0F7, {64'h1, 64'h2}, 64'h22, 64'h0, 4'd0);
        step();
        exe_mem = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 4'd0 || wb_data !== 64'h2 || wb_hi_valid !== 1'b1 ||
            wb_hi_data !== 64'h1 || mem_blocked !== 1'b0) begin
            errors++; $display("FAIL reg_imul got v=%b r=%h d=%h hv=%b hd=%h blk=%b exp v=1 r=0 d=2 hv=1 hd=1 blk=0",
                wb_valid, wb_reg, wb_data, wb_hi_valid, wb_hi_data, mem_blocked);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0 || wb_hi_valid !== 1'b0) begin
            errors++; $display("FAIL reg_pulse got v=%b hv=%b exp 0 0", wb_valid, wb_hi_valid);
        end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        int blk_cycles = 0;
        drive(10'h040, 128'h999, 64'h5, 64'h1000, 4'd7);
        step();
        exe_mem = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h1000) begin
            errors++; $display("FAIL load_req got req=%b we=%b addr=%h exp 1 0 1000", dmem_req, dmem_we, dmem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            if (dmem_req === 1'b1) req_cycles++;
            if (mem_blocked === 1'b1) blk_cycles++;
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++; $display("FAIL load_early_wb cycle %0d got %b exp 0", i, wb_valid);
            end
            if (i == 2) begin
                dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
            end
            step();
        end
        dmem_ack = 1'b0; dmem_rdata = 64'h0;
        checks++;
        if (req_cycles != 3 || blk_cycles != 3) begin
            errors++; $display("FAIL load_req_len got req=%0d blk=%0d exp 3 3", req_cycles, blk_cycles);
        end
        checks++;
        if (dmem_req !== 1'b0 || mem_blocked !== 1'b0 || wb_valid !== 1'b1 || wb_reg !== 4'd7 || wb_data !== 64'hDEAD) begin
            errors++; $display("FAIL load_retire got req=%b blk=%b v=%b r=%h d=%h exp 0 0 1 7 dead",
                dmem_req, mem_blocked, wb_valid, wb_reg, wb_data);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL load_pulse got %b exp 0", wb_valid);
        end
    endtask

    task automatic test_push_queued();
        drive(10'h050, 128'hAB, 64'h3, 64'h7FF8, 4'd9);
        step();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 64'hAB || dmem_addr !== 64'h7FF8 || mem_blocked !== 1'b1) begin
            errors++; $display("FAIL push_req got req=%b we=%b wd=%h addr=%h blk=%b exp 1 1 ab 7ff8 1",
                dmem_req, dmem_we, dmem_wdata, dmem_addr, mem_blocked);
        end
        drive(10'h001, 128'h77, 64'h44, 64'h0, 4'd5);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_blocked !== 1'b0 || wb_rflags !== 64'h3) begin
            errors++; $display("FAIL push_ack got req=%b v=%b blk=%b fl=%h exp 0 0 0 3",
                dmem_req, wb_valid, mem_blocked, wb_rflags);
        end
        step();
        exe_mem = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 4'd5 || wb_data !== 64'h77 || wb_rflags !== 64'h44) begin
            errors++; $display("FAIL queued_reg got v=%b r=%h d=%h fl=%h exp 1 5 77 44", wb_valid, wb_reg, wb_data, wb_rflags);
        end
        step();
    endtask

    task automatic test_nowb();
        drive(10'h038, 128'h1234, 64'h40, 64'h0, 4'd1);
        dmem_ack = 1'b1;
        step();
        exe_mem = 1'b0;
        checks++;
        if (wb_rflags !== 64'h40 || wb_valid !== 1'b0 || mem_blocked !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL nowb_cmp got fl=%h v=%b blk=%b req=%b exp 40 0 0 0",
                wb_rflags, wb_valid, mem_blocked, dmem_req);
        end
        step();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL idle_ack got v=%b req=%b exp 0 0", wb_valid, dmem_req);
        end
    endtask

    task automatic test_class_edges();
        // 0x18F is NOWB, 0x190 is REG, 0x05F is POP, 0x057 is PUSH
        drive(10'h18F, 128'h1, 64'h0, 64'h0, 4'd2);
        step();
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL edge_18f got v=%b req=%b exp 0 0", wb_valid, dmem_req);
        end
        drive(10'h190, 128'h66, 64'h0, 64'h0, 4'd2);
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 64'h66) begin
            errors++; $display("FAIL edge_190 got v=%b d=%h exp 1 66", wb_valid, wb_data);
        end
        drive(10'h05F, 128'h0, 64'h0, 64'h88, 4'd4);
        step();
        exe_mem = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
            errors++; $display("FAIL edge_05f got req=%b we=%b exp 1 0", dmem_req, dmem_we);
        end
        dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 4'd4 || wb_data !== 64'hBEEF) begin
            errors++; $display("FAIL pop_retire got v=%b r=%h d=%h exp 1 4 beef", wb_valid, wb_reg, wb_data);
        end
        drive(10'h057, 128'h55, 64'h0, 64'h90, 4'd4);
        step();
        exe_mem = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 64'h55) begin
            errors++; $display("FAIL edge_057 got req=%b we=%b wd=%h exp 1 1 55", dmem_req, dmem_we, dmem_wdata);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL push_nowb got v=%b req=%b exp 0 0", wb_valid, dmem_req);
        end
    endtask

    task automatic test_reset_mid_req();
        drive(10'h040, 128'h0, 64'h9, 64'h2000, 4'd6);
        step();
        exe_mem = 1'b0;
        checks++;
        if (dmem_req !== 1'b1 || mem_blocked !== 1'b1) begin
            errors++; $display("FAIL rst_setup got req=%b blk=%b exp 1 1", dmem_req, mem_blocked);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_blocked !== 1'b0 || wb_valid !== 1'b0 || wb_rflags !== 64'h0 || dmem_addr !== 64'h0) begin
            errors++; $display("FAIL rst_async got req=%b blk=%b v=%b fl=%h addr=%h exp 0 0 0 0 0",
                dmem_req, mem_blocked, wb_valid, wb_rflags, dmem_addr);
        end
        #1 reset_n = 1'b1;
        drive(10'h002, 128'h31, 64'h7, 64'h0, 4'd8);
        step();
        exe_mem = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_reg !== 4'd8 || wb_data !== 64'h31 || mem_blocked !== 1'b0) begin
            errors++; $display("FAIL rst_after got v=%b r=%h d=%h blk=%b exp 1 8 31 0", wb_valid, wb_reg, wb_data, mem_blocked);
        end
        step();
    endtask

`ifdef MEM_WB_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles = 0;
        drive(10'h058, 128'h0, 64'h0, 64'h20, 4'd2);
        step();
        exe_mem = 1'b0;
        for (int i = 0; i < 20 && dmem_req === 1'b1; i++) begin
            req_cycles++;
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++; $display("FAIL to_wb cycle %0d got %b exp 0", i, wb_valid);
            end
            step();
        end
        checks++;
        if (req_cycles != 4 || mem_err !== 1'b1 || mem_blocked !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL to_abort got req=%0d err=%b blk=%b v=%b exp 4 1 0 0",
                req_cycles, mem_err, mem_blocked, wb_valid);
        end
        drive(10'h003, 128'h12, 64'h0, 64'h0, 4'd1);
        step();
        exe_mem = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 64'h12 || mem_err !== 1'b1) begin
            errors++; $display("FAIL to_next got v=%b d=%h err=%b exp 1 12 1", wb_valid, wb_data, mem_err);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_reg_stream();
        test_load();
        test_push_queued();
        test_nowb();
        test_class_edges();
        test_reset_mid_req();
`ifdef MEM_WB_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL err_tied got %b exp 0", mem_err);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
